// File: rtl/eular_pipe_pkg.sv
// Shared types and defaults for the Euler-solver inter-stage pipeline buffer.
package eular_pipe_pkg;

  localparam int DEF_CH    = 2;
  localparam int DEF_W     = 4;
  localparam int DEF_CNT_W = 16;

  localparam logic [1:0] ENC_EMPTY = 2'd0;
  localparam logic [1:0] ENC_ONE   = 2'd1;
  localparam logic [1:0] ENC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    EMPTY = ENC_EMPTY,
    ONE   = ENC_ONE,
    FULL  = ENC_FULL
  } buf_state_t;

endpackage

// File: rtl/eular_pipe_slot.sv
// One data slot of the pipeline buffer: load-enabled register with synchronous clear.
module eular_pipe_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          load,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/eular_pipe_buffer.sv
// Valid/ready pipeline buffer with flush and saturating stall counter.
// Define EULAR_PIPE_BUF_SKID_EN for the two-slot skid variant with a registered in_ready.
//
// state | meaning
// EMPTY | no item held, out_valid low
// ONE   | main slot M holds the output item
// FULL  | M and skid slot S both hold items, in_ready low (skid build only)
module eular_pipe_buffer
  import eular_pipe_pkg::*;
#(
  parameter int CH    = DEF_CH,
  parameter int W     = DEF_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH*W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH*W-1:0]   out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int DW = CH * W;

  buf_state_t state, state_nxt;
  logic in_fire, out_fire;
  logic m_load;
  logic [DW-1:0] m_d;

  assign out_valid = (state != EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

`ifdef EULAR_PIPE_BUF_SKID_EN
  logic s_load, m_from_s, in_ready_q;
  logic [DW-1:0] s_q;

  assign in_ready = in_ready_q;
  assign m_d      = m_from_s ? s_q : in_data;

  eular_pipe_slot #(.DW(DW)) u_slot_s (
    .clk  (clk),
    .clr  (rst),
    .load (s_load),
    .d    (in_data),
    .q    (s_q)
  );

  // Registered from next state so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst || flush) in_ready_q <= 1'b1;
    else              in_ready_q <= (state_nxt != FULL);
  end
`else
  assign in_ready = ~out_valid | out_ready;
  assign m_d      = in_data;
`endif

  eular_pipe_slot #(.DW(DW)) u_slot_m (
    .clk  (clk),
    .clr  (rst),
    .load (m_load),
    .d    (m_d),
    .q    (out_data)
  );

  always_ff @(posedge clk) begin
    if (rst || flush) state <= EMPTY;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    m_load    = 1'b0;
`ifdef EULAR_PIPE_BUF_SKID_EN
    s_load    = 1'b0;
    m_from_s  = 1'b0;
`endif
    case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nxt = ONE;
          m_load    = 1'b1;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          m_load = 1'b1;
`ifdef EULAR_PIPE_BUF_SKID_EN
        end else if (in_fire) begin
          state_nxt = FULL;
          s_load    = 1'b1;
`endif
        end else if (out_fire) begin
          state_nxt = EMPTY;
        end
      end
`ifdef EULAR_PIPE_BUF_SKID_EN
      FULL: begin
        if (out_fire) begin
          state_nxt = ONE;
          m_load    = 1'b1;
          m_from_s  = 1'b1;
        end
      end
`endif
      default: state_nxt = EMPTY;
    endcase
    // Flush and reset drop the offered item; data slots keep contents on flush.
    if (rst || flush) begin
      state_nxt = EMPTY;
      m_load    = 1'b0;
`ifdef EULAR_PIPE_BUF_SKID_EN
      s_load    = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_eular_pipe_buffer.sv
// Self-checking bench for eular_pipe_buffer: queue-based reference model plus directed and random traffic.
module tb_eular_pipe_buffer;

  localparam int CH    = 2;
  localparam int W     = 4;
  localparam int CNT_W = 4;
  localparam int DW    = CH * W;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CNT_W-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference: items held are a FIFO; capacity 2 with skid, 1 without.
  logic [DW-1:0] model_q[$];
  int stall_m = 0;

  always #5 clk = ~clk;

  eular_pipe_buffer #(.CH(CH), .W(W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .stall_cnt (stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic model_in_ready(input logic ordy);
`ifdef EULAR_PIPE_BUF_SKID_EN
    return model_q.size() < 2;
`else
    return (model_q.size() == 0) || ordy;
`endif
  endfunction

  task automatic cycle(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] d, input logic ordy);
    logic exp_ov, exp_ir, in_fire, out_fire;
    @(negedge clk);
    rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ov = (model_q.size() > 0);
    exp_ir = model_in_ready(ordy);
    check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    check("stall_cnt", 32'(stall_cnt), 32'(stall_m));
    if (exp_ov) check("out_data", 32'(out_data), 32'(model_q[0]));
    in_fire  = iv && exp_ir;
    out_fire = exp_ov && ordy;
    @(posedge clk);
    if (r || f) begin
      model_q.delete();
      stall_m = 0;
    end else begin
      if (exp_ov && !ordy && stall_m != STALL_MAX) stall_m++;
      if (out_fire) void'(model_q.pop_front());
      if (in_fire) model_q.push_back(d);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held three cycles, then released
    repeat (3) cycle(1, 0, 1, 8'h99, 0);
    cycle(0, 0, 0, 8'h00, 1);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Back-to-back stream with out_ready high
    cycle(0, 0, 1, 8'h12, 1);
    #1 check("stream_first", 32'(out_data), 32'h12);
    cycle(0, 0, 1, 8'h34, 1);
    #1 check("stream_second", 32'(out_data), 32'h34);
    cycle(0, 0, 1, 8'h56, 1);
    #1 check("stream_third", 32'(out_data), 32'h56);
    cycle(0, 0, 0, 8'h00, 1);
    cycle(0, 0, 0, 8'h00, 1);

    // Downstream stall with two items offered
    cycle(0, 0, 1, 8'hA1, 0);
    cycle(0, 0, 1, 8'hB2, 0);
    #1;
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_out_data", 32'(out_data), 32'hA1);
    check("stall_count_one", 32'(stall_cnt), 32'd1);
`ifndef EULAR_PIPE_BUF_SKID_EN
    cycle(0, 0, 1, 8'hB2, 1);
`endif
    repeat (3) cycle(0, 0, 0, 8'h00, 1);

    // Stall counter saturation
    cycle(0, 0, 1, 8'hC3, 0);
    repeat ((1 << CNT_W) + 5) cycle(0, 0, 0, 8'h00, 0);
    #1 check("stall_saturate", 32'(stall_cnt), 32'h0F);

    // Flush while holding data, item offered during flush is discarded
    cycle(0, 0, 1, 8'hD4, 0);
    cycle(0, 1, 1, 8'hCC, 0);
    #1;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_stall_cnt", 32'(stall_cnt), 32'd0);
    repeat (3) cycle(0, 0, 0, 8'h00, 1);

    // Reset and flush together with items held
    cycle(0, 0, 1, 8'hE5, 0);
    cycle(0, 0, 1, 8'hF6, 0);
    cycle(1, 1, 1, 8'h77, 0);
    #1;
    check("rstflush_out_data", 32'(out_data), 32'h00);
    check("rstflush_out_valid", {31'd0, out_valid}, 32'd0);
    check("rstflush_in_ready", {31'd0, in_ready}, 32'd1);
    check("rstflush_stall_cnt", 32'(stall_cnt), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic r, f, iv, ordy;
      r    = ($urandom_range(0, 99) == 0);
      f    = ($urandom_range(0, 39) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = (i % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      cycle(r, f, iv, DW'($urandom), ordy);
    end
    repeat (4) cycle(0, 0, 0, 8'h00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
